// File: rtl/sopc_mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its masters and the shared RAM port.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface sopc_mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8
);
    logic [NUM_MASTERS-1:0]            m_req_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [DATA_WIDTH-1:0]             m_data_o;
    logic                              mem_ce_o;
    logic                              mem_we_o;
    logic [ADDR_WIDTH-1:0]             mem_addr_o;
    logic [SEL_WIDTH-1:0]              mem_sel_o;
    logic [DATA_WIDTH-1:0]             mem_data_o;
    logic [DATA_WIDTH-1:0]             mem_data_i;
    logic                              busy_o;
    logic [2:0]                        grant_o;

    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_sel_i, m_data_i, mem_data_i,
        output m_ack_o, m_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o,
               mem_data_o, busy_o, grant_o
    );

    modport master (
        output m_req_i, m_we_i, m_addr_i, m_sel_i, m_data_i, mem_data_i,
        input  m_ack_o, m_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o,
               mem_data_o, busy_o, grant_o
    );
endinterface

// File: rtl/sopc_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between NUM_MASTERS masters.
// One access in flight at a time; read data is captured RAM_LATENCY cycles after issue.
module sopc_mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    sopc_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [NUM_MASTERS-1:0] ACK_ONE   = NUM_MASTERS'(1);
    localparam logic [2:0]             GRANT_RST = 3'(NUM_MASTERS - 1);
    localparam logic [1:0]             LAT_LOAD  = 2'(RAM_LATENCY - 1);

    state_t                  state;
    logic [1:0]              lat_cnt;
    logic [2:0]              grant;

    logic                    found;
    logic [2:0]              pick;
    logic [2:0]              cand;
    logic [7:0]              req8;
    logic                    pick_we;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic [SEL_WIDTH-1:0]    pick_sel;
    logic [DATA_WIDTH-1:0]   pick_data;

    // Search starts just past the last grant so the master served last ranks lowest.
    always_comb begin
        found = 1'b0;
        pick  = grant;
        cand  = '0;
        req8  = 8'(bus.m_req_i);
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = 3'((int'(grant) + k) % NUM_MASTERS);
            if (!found && req8[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_we   = 1'b0;
        pick_addr = '0;
        pick_sel  = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick == 3'(i)) begin
                pick_we   = bus.m_we_i[i];
                pick_addr = bus.m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_sel  = bus.m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                pick_data = bus.m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            grant          <= GRANT_RST;
            bus.m_ack_o    <= '0;
            bus.m_data_o   <= '0;
            bus.mem_ce_o   <= 1'b0;
            bus.mem_we_o   <= 1'b0;
            bus.mem_addr_o <= '0;
            bus.mem_sel_o  <= '0;
            bus.mem_data_o <= '0;
            bus.busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant          <= pick;
                        bus.mem_ce_o   <= 1'b1;
                        bus.mem_we_o   <= pick_we;
                        bus.mem_addr_o <= pick_addr;
                        bus.mem_sel_o  <= pick_sel;
                        bus.mem_data_o <= pick_data;
                        bus.busy_o     <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_ce_o <= 1'b0;
                    bus.mem_we_o <= 1'b0;
                    lat_cnt      <= LAT_LOAD;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        bus.m_data_o <= bus.mem_data_i;
                        bus.m_ack_o  <= ACK_ONE << grant;
                        state        <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                DONE: begin
                    bus.m_ack_o <= '0;
                    bus.busy_o  <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_o = grant;
endmodule
